// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Write side of the integer register file. Results from the ALU, the CSR
//   unit and the load/store unit are merged into the single regfile write
//   port. Load returns are byte/half selected and extended on entry to a
//   small FIFO. Fixed priority is LSU FIFO > CSR > ALU. An anti-starvation
//   counter forces an ALU grant after STARVE_LIMIT consecutive denied cycles.
//   All wb_* outputs are registered.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
//   both high. Each ready is a function of FIFO/arbiter state and of the other
//   channels only, never of its own channel's valid. All readies are low
//   while rst is high.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid/ready/rd/result     ALU result channel
//   csr_valid/ready/rd/rdata      CSR read-data channel
//   lsu_valid/ready/rd/data       load-return channel (raw aligned word)
//   lsu_funct3, lsu_addr_lo       load type and byte offset
//   wb_rd, wb_result              regfile destination and data
//   wb_reg_write, wb_csr_write    regfile write enables (ALU/LSU, CSR)
//   pend_mask                     bit r set while a queued load targets xr
module writeback_arbiter #(
    parameter int XLEN           = 32,
    parameter int LSU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            csr_valid,
    output logic            csr_ready,
    input  logic [4:0]      csr_rd,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [2:0]      lsu_funct3,
    input  logic [1:0]      lsu_addr_lo,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_result,
    output logic            wb_reg_write,
    output logic            wb_csr_write,
    output logic [31:0]     pend_mask
);

    localparam int PW = $clog2(LSU_FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   DEPTH_C = LSU_FIFO_DEPTH[PW:0];
    localparam logic [CW-1:0] LIMIT_C = STARVE_LIMIT[CW-1:0];

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_LSU  = 2'd1,
        G_CSR  = 2'd2,
        G_ALU  = 2'd3
    } grant_t;

    logic [4:0]          fifo_rd   [LSU_FIFO_DEPTH];
    logic [XLEN-1:0]     fifo_data [LSU_FIFO_DEPTH];
    logic [LSU_FIFO_DEPTH-1:0] fifo_occ;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW:0]         count;
    logic [CW-1:0]       starve_cnt;

    logic   fifo_empty;
    logic   fifo_full;
    logic   starve_force;
    logic   push;
    logic   pop;
    grant_t grant;

    // Byte/half selection and extension of the raw load word.
    function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] word,
                                                    input logic [2:0]      f3,
                                                    input logic [1:0]      lo);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  format_load = {{(XLEN-8){b[7]}}, b};
            3'b001:  format_load = {{(XLEN-16){h[15]}}, h};
            3'b100:  format_load = {{(XLEN-8){1'b0}}, b};
            3'b101:  format_load = {{(XLEN-16){1'b0}}, h};
            default: format_load = word;
        endcase
    endfunction

    always_comb begin
        fifo_empty   = (count == '0);
        fifo_full    = (count == DEPTH_C);
        starve_force = (starve_cnt == LIMIT_C);

        // The forced ALU grant only takes effect if the ALU is actually
        // offering; otherwise normal priority applies.
        lsu_ready = !rst && !fifo_full;
        csr_ready = !rst && fifo_empty && !(starve_force && alu_valid);
        alu_ready = !rst && (starve_force || (fifo_empty && !csr_valid));

        grant = G_NONE;
        if (!rst) begin
            if (alu_valid && starve_force) grant = G_ALU;
            else if (!fifo_empty)          grant = G_LSU;
            else if (csr_valid)            grant = G_CSR;
            else if (alu_valid)            grant = G_ALU;
        end

        push = lsu_valid && lsu_ready;
        pop  = (grant == G_LSU);

        pend_mask = '0;
        for (int i = 0; i < LSU_FIFO_DEPTH; i++) begin
            if (fifo_occ[i] && (fifo_rd[i] != 5'd0)) pend_mask[fifo_rd[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_occ     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            starve_cnt   <= '0;
            wb_rd        <= '0;
            wb_result    <= '0;
            wb_reg_write <= 1'b0;
            wb_csr_write <= 1'b0;
        end else begin
            // Push and pop never hit the same slot: a pop needs an occupied
            // head and a push needs a free tail.
            if (pop) begin
                fifo_occ[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            if (push) begin
                fifo_rd[wr_ptr]   <= lsu_rd;
                fifo_data[wr_ptr] <= format_load(lsu_data, lsu_funct3, lsu_addr_lo);
                fifo_occ[wr_ptr]  <= 1'b1;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (!alu_valid || grant == G_ALU) starve_cnt <= '0;
            else if (starve_cnt != LIMIT_C)   starve_cnt <= starve_cnt + 1'b1;

            wb_reg_write <= 1'b0;
            wb_csr_write <= 1'b0;
            case (grant)
                G_LSU: begin
                    wb_rd        <= fifo_rd[rd_ptr];
                    wb_result    <= fifo_data[rd_ptr];
                    wb_reg_write <= (fifo_rd[rd_ptr] != 5'd0);
                end
                G_CSR: begin
                    wb_rd        <= csr_rd;
                    wb_result    <= csr_rdata;
                    wb_csr_write <= (csr_rd != 5'd0);
                end
                G_ALU: begin
                    wb_rd        <= alu_rd;
                    wb_result    <= alu_result;
                    wb_reg_write <= (alu_rd != 5'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//   Directed bench for writeback_arbiter: reset, ALU-only write, load
//   formatting, three-way contention, ALU starvation, FIFO full / rd=0 load,
//   and reset with a full FIFO.
module tb_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        csr_valid;
    logic        csr_ready;
    logic [4:0]  csr_rd;
    logic [31:0] csr_rdata;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [2:0]  lsu_funct3;
    logic [1:0]  lsu_addr_lo;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        wb_reg_write;
    logic        wb_csr_write;
    logic [31:0] pend_mask;

    int checks = 0;
    int errors = 0;

    writeback_arbiter #(
        .XLEN(32),
        .LSU_FIFO_DEPTH(2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_rd(alu_rd),
        .alu_result(alu_result),
        .csr_valid(csr_valid),
        .csr_ready(csr_ready),
        .csr_rd(csr_rd),
        .csr_rdata(csr_rdata),
        .lsu_valid(lsu_valid),
        .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd),
        .lsu_data(lsu_data),
        .lsu_funct3(lsu_funct3),
        .lsu_addr_lo(lsu_addr_lo),
        .wb_rd(wb_rd),
        .wb_result(wb_result),
        .wb_reg_write(wb_reg_write),
        .wb_csr_write(wb_csr_write),
        .pend_mask(pend_mask)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_result  = '0;
        csr_valid   = 1'b0;
        csr_rd      = '0;
        csr_rdata   = '0;
        lsu_valid   = 1'b0;
        lsu_rd      = '0;
        lsu_data    = '0;
        lsu_funct3  = 3'b010;
        lsu_addr_lo = 2'd0;
    endtask

    // Fills the FIFO to two entries: CSR+ALU build the starve counter up to
    // 4 while the first load is pushed on the 4th edge, and the forced ALU
    // grant on the 5th edge keeps the FIFO from draining while the second
    // load is pushed.
    task automatic fill_two(input logic [4:0] rd_a, input logic [4:0] rd_b);
        csr_valid  = 1'b1;
        csr_rd     = 5'd11;
        csr_rdata  = 32'h0000_0C11;
        alu_valid  = 1'b1;
        alu_rd     = 5'd12;
        alu_result = 32'h0000_0A12;
        step();
        step();
        step();
        lsu_valid  = 1'b1;
        lsu_funct3 = 3'b010;
        lsu_rd     = rd_a;
        lsu_data   = 32'hD000_0000 | {27'd0, rd_a};
        step();
        lsu_rd     = rd_b;
        lsu_data   = 32'hD000_0000 | {27'd0, rd_b};
        step();
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        checks++;
        if ({wb_reg_write, wb_csr_write} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00", {wb_reg_write, wb_csr_write});
        end
        checks++;
        if (wb_rd !== 5'd0 || wb_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got rd=%0d result=%h expected rd=0 result=0", wb_rd, wb_result);
        end
        checks++;
        if (pend_mask !== 32'd0) begin
            errors++;
            $display("FAIL reset_pend: got %h expected 0", pend_mask);
        end
        checks++;
        if ({lsu_ready, csr_ready, alu_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 000", {lsu_ready, csr_ready, alu_ready});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_alu_only();
        alu_valid  = 1'b1;
        alu_rd     = 5'd5;
        alu_result = 32'h0000_1234;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL alu_ready: got %b expected 1", alu_ready);
        end
        step();
        alu_valid = 1'b0;
        checks++;
        if (wb_rd !== 5'd5 || wb_result !== 32'h1234 || wb_reg_write !== 1'b1 || wb_csr_write !== 1'b0) begin
            errors++;
            $display("FAIL alu_write: got rd=%0d result=%h rw=%b cw=%b expected rd=5 result=1234 rw=1 cw=0",
                     wb_rd, wb_result, wb_reg_write, wb_csr_write);
        end
        step();
        checks++;
        if (wb_reg_write !== 1'b0 || wb_rd !== 5'd5) begin
            errors++;
            $display("FAIL alu_idle_hold: got rw=%b rd=%0d expected rw=0 rd=5", wb_reg_write, wb_rd);
        end
    endtask

    task automatic test_load_format();
        logic [2:0]  f3_v  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  off_v [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
        logic [31:0] exp_v [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                                   32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            lsu_valid   = 1'b1;
            lsu_rd      = 5'(i + 1);
            lsu_data    = 32'h80FF_7F01;
            lsu_funct3  = f3_v[i];
            lsu_addr_lo = off_v[i];
            step();
            lsu_valid = 1'b0;
            #1;
            checks++;
            if (pend_mask !== (32'd1 << (i + 1))) begin
                errors++;
                $display("FAIL load_pend[%0d]: got %h expected %h", i, pend_mask, 32'd1 << (i + 1));
            end
            step();
            checks++;
            if (wb_result !== exp_v[i] || wb_rd !== 5'(i + 1) || wb_reg_write !== 1'b1) begin
                errors++;
                $display("FAIL load_format[%0d]: got rd=%0d result=%h rw=%b expected rd=%0d result=%h rw=1",
                         i, wb_rd, wb_result, wb_reg_write, i + 1, exp_v[i]);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_contention();
        lsu_valid   = 1'b1;
        lsu_rd      = 5'd13;
        lsu_data    = 32'h80FF_7F01;
        lsu_funct3  = 3'b000;
        lsu_addr_lo = 2'd0;
        step();
        lsu_valid  = 1'b0;
        csr_valid  = 1'b1;
        csr_rd     = 5'd14;
        csr_rdata  = 32'h0000_00CC;
        alu_valid  = 1'b1;
        alu_rd     = 5'd15;
        alu_result = 32'h0000_00AA;
        #1;
        checks++;
        if ({csr_ready, alu_ready} !== 2'b00) begin
            errors++;
            $display("FAIL cont_ready_blocked: got %b expected 00", {csr_ready, alu_ready});
        end
        step();
        checks++;
        if (wb_rd !== 5'd13 || wb_result !== 32'h1 || {wb_reg_write, wb_csr_write} !== 2'b10) begin
            errors++;
            $display("FAIL cont_lsu: got rd=%0d result=%h flags=%b expected rd=13 result=1 flags=10",
                     wb_rd, wb_result, {wb_reg_write, wb_csr_write});
        end
        step();
        csr_valid = 1'b0;
        checks++;
        if (wb_rd !== 5'd14 || wb_result !== 32'hCC || {wb_reg_write, wb_csr_write} !== 2'b01) begin
            errors++;
            $display("FAIL cont_csr: got rd=%0d result=%h flags=%b expected rd=14 result=cc flags=01",
                     wb_rd, wb_result, {wb_reg_write, wb_csr_write});
        end
        step();
        alu_valid = 1'b0;
        checks++;
        if (wb_rd !== 5'd15 || wb_result !== 32'hAA || {wb_reg_write, wb_csr_write} !== 2'b10) begin
            errors++;
            $display("FAIL cont_alu: got rd=%0d result=%h flags=%b expected rd=15 result=aa flags=10",
                     wb_rd, wb_result, {wb_reg_write, wb_csr_write});
        end
        idle_inputs();
        step();
    endtask

    task automatic test_starvation();
        csr_valid  = 1'b1;
        csr_rd     = 5'd9;
        csr_rdata  = 32'h0000_00C5;
        alu_valid  = 1'b1;
        alu_rd     = 5'd10;
        alu_result = 32'h0000_00A1;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if ({wb_csr_write, wb_reg_write, wb_rd} !== {1'b1, 1'b0, 5'd9}) begin
                errors++;
                $display("FAIL starve_csr_cycle%0d: got cw=%b rw=%b rd=%0d expected cw=1 rw=0 rd=9",
                         i, wb_csr_write, wb_reg_write, wb_rd);
            end
        end
        checks++;
        if ({alu_ready, csr_ready} !== 2'b10) begin
            errors++;
            $display("FAIL starve_ready: got alu/csr=%b expected 10", {alu_ready, csr_ready});
        end
        step();
        alu_valid = 1'b0;
        checks++;
        if (wb_rd !== 5'd10 || wb_result !== 32'hA1 || {wb_reg_write, wb_csr_write} !== 2'b10) begin
            errors++;
            $display("FAIL starve_alu_grant: got rd=%0d result=%h flags=%b expected rd=10 result=a1 flags=10",
                     wb_rd, wb_result, {wb_reg_write, wb_csr_write});
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_fifo_full();
        fill_two(5'd3, 5'd6);
        checks++;
        if (lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_lsu_ready: got %b expected 0", lsu_ready);
        end
        checks++;
        if (pend_mask !== 32'h0000_0048) begin
            errors++;
            $display("FAIL full_pend: got %h expected 00000048", pend_mask);
        end
        // Offer a load while full; it must not slip in alongside the pop.
        lsu_valid  = 1'b1;
        lsu_rd     = 5'd20;
        lsu_data   = 32'h1234_5678;
        lsu_funct3 = 3'b010;
        step();
        lsu_valid = 1'b0;
        #1;
        checks++;
        if (wb_rd !== 5'd3 || wb_result !== 32'hD000_0003 || wb_reg_write !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_first: got rd=%0d result=%h rw=%b expected rd=3 result=d0000003 rw=1",
                     wb_rd, wb_result, wb_reg_write);
        end
        checks++;
        if (pend_mask !== 32'h0000_0040) begin
            errors++;
            $display("FAIL full_no_passthru: got %h expected 00000040", pend_mask);
        end
        step();
        checks++;
        if (wb_rd !== 5'd6 || wb_reg_write !== 1'b1 || pend_mask !== 32'd0) begin
            errors++;
            $display("FAIL full_pop_second: got rd=%0d rw=%b pend=%h expected rd=6 rw=1 pend=0",
                     wb_rd, wb_reg_write, pend_mask);
        end
        step();
        // Load to x0: accepted and popped, never flagged.
        lsu_valid = 1'b1;
        lsu_rd    = 5'd0;
        lsu_data  = 32'hFFFF_FFFF;
        step();
        lsu_valid = 1'b0;
        #1;
        checks++;
        if (pend_mask !== 32'd0 || csr_ready !== 1'b0) begin
            errors++;
            $display("FAIL x0_queued: got pend=%h csr_ready=%b expected pend=0 csr_ready=0", pend_mask, csr_ready);
        end
        step();
        checks++;
        if (wb_reg_write !== 1'b0 || wb_csr_write !== 1'b0 || csr_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_popped: got rw=%b cw=%b csr_ready=%b expected rw=0 cw=0 csr_ready=1",
                     wb_reg_write, wb_csr_write, csr_ready);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        fill_two(5'd7, 5'd8);
        checks++;
        if (pend_mask !== 32'h0000_0180) begin
            errors++;
            $display("FAIL mid_pend_before: got %h expected 00000180", pend_mask);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({wb_reg_write, wb_csr_write} !== 2'b00 || pend_mask !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: got flags=%b pend=%h expected flags=00 pend=0",
                     {wb_reg_write, wb_csr_write}, pend_mask);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({wb_reg_write, wb_csr_write} !== 2'b00) begin
                errors++;
                $display("FAIL mid_stale_write%0d: got flags=%b rd=%0d expected flags=00",
                         i, {wb_reg_write, wb_csr_write}, wb_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_load_format();
        test_contention();
        test_starvation();
        test_fifo_full();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
